// File: rtl/display_scan_arbiter.sv
// rtl/display_scan_arbiter.sv - shared 4-digit 7-segment scan, arbitration, blink and alarm flash
module display_scan_arbiter #(
    parameter logic [15:0] SCAN_DIV  = 16'd16384,
    parameter logic [23:0] BLINK_DIV = 24'd4000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] val_bus,
    input  logic [15:0] blink_bus,
    input  logic [15:0] time_val,
    input  logic        alarm_flash,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic [4:0]  grant,
    output logic        frame_tick
);

    logic [15:0] scan_cnt;
    logic [1:0]  digit;
    logic [23:0] blink_cnt;
    logic        blink_phase;
    logic [4:0]  next_grant;
    logic [15:0] cur_val;
    logic [3:0]  cur_mask;
    logic [3:0]  nibble;
    logic [6:0]  seg_next;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Last cycle of digit 3 closes the frame; grant may only move here.
    assign frame_tick = (scan_cnt == SCAN_DIV - 16'd1) && (digit == 2'd3);

    // Lowest-numbered requester wins; the running clock owns the display otherwise.
    always_comb begin
        next_grant = 5'b10000;
        if (req[0])      next_grant = 5'b00001;
        else if (req[1]) next_grant = 5'b00010;
        else if (req[2]) next_grant = 5'b00100;
        else if (req[3]) next_grant = 5'b01000;
    end

    // Pick the granted value and blink mask, then resolve flash/blink/non-BCD blanking.
    always_comb begin
        cur_val  = time_val;
        cur_mask = 4'b0000;
        case (grant)
            5'b00001: begin cur_val = val_bus[15:0];  cur_mask = blink_bus[3:0];   end
            5'b00010: begin cur_val = val_bus[31:16]; cur_mask = blink_bus[7:4];   end
            5'b00100: begin cur_val = val_bus[47:32]; cur_mask = blink_bus[11:8];  end
            5'b01000: begin cur_val = val_bus[63:48]; cur_mask = blink_bus[15:12]; end
            default:  begin cur_val = time_val;       cur_mask = 4'b0000;          end
        endcase
        nibble = cur_val[{digit, 2'b00} +: 4];
        if (alarm_flash)
            seg_next = blink_phase ? 7'b0000000 : 7'b1111111;
        else if (!blink_phase && cur_mask[digit])
            seg_next = 7'b1111111;
        else
            seg_next = bcd_to_seg(nibble);
    end

    // Scan counter and digit index; grant latches at the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= 16'd0;
            digit    <= 2'd0;
            grant    <= 5'b10000;
        end else begin
            if (scan_cnt == SCAN_DIV - 16'd1) begin
                scan_cnt <= 16'd0;
                digit    <= digit + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
            if (frame_tick)
                grant <= next_grant;
        end
    end

    // Free-running blink timebase, independent of the scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= 24'd0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_DIV - 24'd1) begin
            blink_cnt   <= 24'd0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end

    // Registered pin drive, one cycle behind the digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode <= 4'b1111;
            seg   <= 7'b1111111;
        end else begin
            anode <= ~(4'b0001 << digit);
            seg   <= seg_next;
        end
    end

endmodule

// File: tb/tb_display_scan_arbiter.sv
// tb/tb_display_scan_arbiter.sv - scoreboard bench for display_scan_arbiter
module tb_display_scan_arbiter;

    localparam int SD = 4;
    localparam int BD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] val_bus;
    logic [15:0] blink_bus;
    logic [15:0] time_val;
    logic        alarm_flash;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [4:0]  grant;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int m_t = 0;
    logic [4:0]  m_grant = 5'b10000;
    logic [16:0] exp_q[$];

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    display_scan_arbiter #(.SCAN_DIV(16'd4), .BLINK_DIV(24'd8)) dut (
        .clk(clk), .reset(reset), .req(req), .val_bus(val_bus), .blink_bus(blink_bus),
        .time_val(time_val), .alarm_flash(alarm_flash), .anode(anode), .seg(seg),
        .grant(grant), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    // One clock: predict what the DUT registers at this edge, then compare after it.
    task automatic step();
        int d;
        int gi;
        bit ph;
        logic [15:0] v;
        logic [3:0]  mask;
        logic [3:0]  nib;
        logic [3:0]  an_e;
        logic [6:0]  sg_e;
        logic        ft_e;
        logic [16:0] e;
        @(posedge clk);
        if (reset) begin
            an_e = 4'b1111; sg_e = 7'b1111111; ft_e = 1'b0;
            m_t = 0; m_grant = 5'b10000;
        end else begin
            d  = (m_t / SD) % 4;
            ph = ((m_t / BD) % 2) == 0;
            v = time_val; mask = 4'b0000;
            for (int i = 0; i < 4; i++)
                if (m_grant[i]) begin
                    v = val_bus[16*i +: 16]; mask = blink_bus[4*i +: 4];
                end
            nib  = v[4*d +: 4];
            an_e = 4'b1111; an_e[d] = 1'b0;
            if (alarm_flash)           sg_e = ph ? 7'b0000000 : 7'b1111111;
            else if (!ph && mask[d])   sg_e = 7'b1111111;
            else                       sg_e = dec_tab[nib];
            if ((m_t % (4*SD)) == 4*SD-1) begin
                gi = 4;
                for (int i = 3; i >= 0; i--) if (req[i]) gi = i;
                m_grant = 5'b00001 << gi;
            end
            ft_e = ((m_t + 1) % (4*SD)) == 4*SD-1;
            m_t++;
        end
        exp_q.push_back({m_grant, an_e, sg_e, ft_e});
        @(negedge clk);
        e = exp_q.pop_front();
        check("grant", {3'b0, grant}, {3'b0, e[16:12]});
        check("anode", {4'b0, anode}, {4'b0, e[11:8]});
        check("seg", {1'b0, seg}, {1'b0, e[7:1]});
        check("frame_tick", {7'b0, frame_tick}, {7'b0, e[0]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; req = 4'b0; val_bus = 64'h0; blink_bus = 16'h0;
        time_val = 16'h1234; alarm_flash = 1'b0;
        run(3);
        check("reset_anode", {4'b0, anode}, 8'h0F);
        check("reset_seg", {1'b0, seg}, 8'h7F);
        reset = 1'b0;

        // Clock default, 1234 on the display.
        run(32);

        // Requests rise at digit1; grant holds until the frame ends.
        val_bus = 64'h0000_0000_5678_4321;
        while ((m_t % 16) != 4) step();
        req = 4'b1010;
        run(8);
        check("grant_hold", {3'b0, grant}, 8'h10);
        while ((m_t % 16) != 0) step();
        check("grant_new", {3'b0, grant}, 8'h02);
        run(20);

        // Requester 0 with digit2 blinking; its request drops mid-frame.
        req = 4'b0001; blink_bus = 16'h0004;
        run(64);
        while ((m_t % 16) != 6) step();
        req = 4'b0000;
        run(26);

        // Alarm flash overrides whatever owns the display.
        req = 4'b0010; alarm_flash = 1'b1;
        run(40);
        alarm_flash = 1'b0;

        // Non-BCD nibble blanks its digit.
        req = 4'b0000; time_val = 16'h00A5;
        run(40);

        // Reset during digit2 while requester 1 is granted.
        req = 4'b0010;
        while (!(m_grant == 5'b00010 && (m_t % 16) == 9)) step();
        reset = 1'b1;
        step();
        check("midreset_anode", {4'b0, anode}, 8'h0F);
        check("midreset_grant", {3'b0, grant}, 8'h10);
        reset = 1'b0;
        step();
        check("resume_anode", {4'b0, anode}, 8'h0E);
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
